// File: rtl/lampfpu_log_rndpack_pkg.sv
// Shared widths, packed-entry type and bfloat16 special-value constants for the
// log-unit round/pack stage.
package lampfpu_log_rndpack_pkg;

  localparam int LAMP_FLOAT_S_DW = 1;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int LAMP_FLOAT_DW   = LAMP_FLOAT_S_DW + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

  // Magnitude encodings; the sign is OR-ed in by the caller.
  localparam logic [LAMP_FLOAT_DW-2:0] BF16_INF_MAG  = 15'h7F80;
  localparam logic [LAMP_FLOAT_DW-2:0] BF16_ZERO_MAG = 15'h0000;
  localparam logic [LAMP_FLOAT_E_DW-1:0] EXP_ALL_ONES = 8'hFF;

  typedef struct packed {
    logic [LAMP_FLOAT_DW-1:0] res;
    logic                     ovf;
    logic                     unf;
    logic                     inx;
  } entry_t;

  function automatic logic [LAMP_FLOAT_DW-1:0] pack_bf16(
    input logic                       s,
    input logic [LAMP_FLOAT_E_DW-1:0] e,
    input logic [LAMP_FLOAT_F_DW-1:0] f
  );
    return {s, e, f};
  endfunction

endpackage

// File: rtl/lampfpu_log_rndpack_rnd.sv
// Combinational rounding and special-case packing of one log-unit result
// into a bfloat16 entry with IEEE flags.
module lampfpu_log_rndpack_rnd
  import lampfpu_log_rndpack_pkg::*;
(
  input  logic                       s,
  input  logic [LAMP_FLOAT_E_DW-1:0] e,
  input  logic [LAMP_FLOAT_F_DW-1:0] f,
  input  logic                       is_overflow,
  input  logic                       is_underflow,
  input  logic                       is_to_round,
  output entry_t                     entry
);

  logic [LAMP_FLOAT_F_DW:0]   f_sum_s;
  logic [LAMP_FLOAT_E_DW-1:0] e_rnd_s;
  logic [LAMP_FLOAT_F_DW-1:0] f_rnd_s;

  // Fraction increment; a carry out renormalises into the exponent.
  always_comb begin
    f_sum_s = {1'b0, f} + {{LAMP_FLOAT_F_DW{1'b0}}, is_to_round};
    if (f_sum_s[LAMP_FLOAT_F_DW]) begin
      e_rnd_s = e + 8'd1;
      f_rnd_s = 7'h00;
    end else begin
      e_rnd_s = e;
      f_rnd_s = f_sum_s[LAMP_FLOAT_F_DW-1:0];
    end
  end

  // Special cases take priority over the rounded value.
  always_comb begin
    entry = '0;
    if (is_overflow) begin
      entry.res = {s, BF16_INF_MAG};
      entry.ovf = 1'b1;
      entry.inx = 1'b1;
    end else if (is_underflow) begin
      entry.res = {s, BF16_ZERO_MAG};
      entry.unf = 1'b1;
      entry.inx = 1'b1;
    end else if (e == EXP_ALL_ONES) begin
      entry.res = pack_bf16(s, e, f);
    end else if (e_rnd_s == EXP_ALL_ONES) begin
      entry.res = {s, BF16_INF_MAG};
      entry.ovf = 1'b1;
      entry.inx = 1'b1;
    end else begin
      entry.res = pack_bf16(s, e_rnd_s, f_rnd_s);
      entry.inx = is_to_round;
    end
  end

endmodule

// File: rtl/lampfpu_log_rndpack.sv
// Log-unit result round/pack stage followed by a small in-order FIFO with
// sticky drop indication when a result arrives while the FIFO is full.
module lampfpu_log_rndpack
  import lampfpu_log_rndpack_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic [LAMP_FLOAT_S_DW-1:0]    s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0]    e_i,
  input  logic [LAMP_FLOAT_F_DW-1:0]    f_i,
  input  logic                          isOverflow_i,
  input  logic                          isUnderflow_i,
  input  logic                          isToRound_i,
  output logic [15:0]                   res_o,
  output logic                          ovf_o,
  output logic                          unf_o,
  output logic                          inx_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          drop_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  entry_t          mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            drop_r;
  entry_t          new_entry_s;
  logic            full_s;
  logic            pop_s;
  logic            push_s;
  logic            lost_s;

  lampfpu_log_rndpack_rnd u_rnd (
    .s            (s_i),
    .e            (e_i),
    .f            (f_i),
    .is_overflow  (isOverflow_i),
    .is_underflow (isUnderflow_i),
    .is_to_round  (isToRound_i),
    .entry        (new_entry_s)
  );

  // Handshake decode; an empty FIFO never pops, so there is no bypass path.
  always_comb begin
    full_s = (count_r == FULL_CNT);
    pop_s  = (count_r != {CW{1'b0}}) && ready_i;
    push_s = valid_i && (!full_s || pop_s);
    lost_s = valid_i && full_s && !pop_s;
  end

  // FIFO storage, pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      drop_r   <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= new_entry_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (lost_s) begin
        drop_r <= 1'b1;
      end
    end
  end

  // Head is read straight from registered storage, so it stays stable while stalled.
  assign res_o   = mem_r[rd_ptr_r].res;
  assign ovf_o   = mem_r[rd_ptr_r].ovf;
  assign unf_o   = mem_r[rd_ptr_r].unf;
  assign inx_o   = mem_r[rd_ptr_r].inx;
  assign valid_o = (count_r != {CW{1'b0}});
  assign count_o = count_r;
  assign drop_o  = drop_r;

endmodule

// File: doc/lampfpu_log_rndpack.md
LAMPFPU_LOG_RNDPACK -- requirements
Module: lampFPU_log_rndpack

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of buffered packed results (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port valid_i  input  1  one-cycle pulse; log result fields below are valid.
REQ-005 SHALL have port s_i  input  LAMP_FLOAT_S_DW  result sign from log unit.
REQ-006 SHALL have port e_i  input  LAMP_FLOAT_E_DW  biased result exponent.
REQ-007 SHALL have port f_i  input  LAMP_FLOAT_F_DW  result fraction (hidden bit excluded).
REQ-008 SHALL have port isOverflow_i  input  1  log unit overflow.
REQ-009 SHALL have port isUnderflow_i  input  1  log unit underflow.
REQ-010 SHALL have port isToRound_i  input  1  round-up request (fraction increment).
REQ-011 SHALL have port res_o  output  16  packed bfloat16 {s,e,f} at FIFO head.
REQ-012 SHALL have port ovf_o / unf_o / inx_o  output  1 each  IEEE flags for res_o.
REQ-013 SHALL have port valid_o  output  1  head entry present.
REQ-014 SHALL have port ready_i  input  1  consumer accepts head when valid_o=1.
REQ-015 SHALL have port count_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-016 SHALL have port drop_o  output  1  sticky: a valid_i was lost while FIFO full.

Function
REQ-017 Rounding SHALL be computed combinationally on inputs and the packed result written into the FIFO on the valid_i edge; latency valid_i -> valid_o is exactly 1 cycle when FIFO empty.
REQ-018 Priority per entry: isOverflow_i -> {s_i,8'hFF,7'h00}, ovf=1, inx=1; else isUnderflow_i -> {s_i,8'h00,7'h00}, unf=1, inx=1; else e_i==8'hFF -> pass through unmodified, no flags; else round.
REQ-019 Round: f_r = f_i + isToRound_i; carry out SHALL zero fraction and increment exponent; exponent reaching 8'hFF SHALL yield signed Inf with ovf=1.
REQ-020 inx SHALL equal isToRound_i OR ovf OR unf for the entry.
REQ-021 Push when valid_i=1 and (count<FIFO_DEPTH or pop same cycle); pop when valid_o=1 and ready_i=1.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, including full and empty-with-bypass-forbidden (empty+push never pops same cycle).
REQ-023 valid_i while full without pop SHALL discard input, set drop_o=1 until reset, not alter FIFO contents.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; entries emerge strictly in arrival order.
REQ-025 res_o and flags SHALL be don't-care but stable-registered when valid_o=0; held unchanged while valid_o=1 and ready_i=0.

Reset
REQ-026 rst=0 at a rising edge SHALL clear pointers, count_o=0, valid_o=0, drop_o=0, res_o=16'h0000, ovf_o=unf_o=inx_o=0, discarding any buffered entries.
REQ-027 valid_i during reset SHALL be ignored; first push accepted on first edge with rst=1.

Structure
REQ-028 Packed-entry struct (res, ovf, unf, inx) and bfloat16 Inf/zero constants SHALL live in lampFPU_pkg alongside LAMP_FLOAT_*_DW.
REQ-029 Rounding/special-case logic SHALL be one combinational sub-module lampFPU_rndPack; FIFO storage stays in the top module.

Verification
REQ-030 s=0,e=0x80,f=0x12,isToRound=1, ready_i=1 -> next cycle valid_o=1, res_o=0x4013, inx_o=1, ovf_o=unf_o=0.
REQ-031 e=0x7F,f=0x7F,isToRound=1 -> res_o=0x4000 (carry into exponent), inx_o=1; e=0xFE,f=0x7F,isToRound=1 -> res_o=0x7F80, ovf_o=1.
REQ-032 s=1,isUnderflow_i=1 -> res_o=0x8000, unf_o=1, inx_o=1; s=0,e=0xFF,f=0x40,isToRound=1 -> res_o=0x7FC0, no flags.
REQ-033 FIFO_DEPTH=2, ready_i=0, three valid_i pulses A,B,C -> count_o=2, drop_o=1; then ready_i=1 -> A, B popped in order, count_o=0, drop_o stays 1.
REQ-034 Full FIFO, ready_i=1 and valid_i=1 same cycle -> count_o stays 2, drop_o=0, order preserved.
REQ-035 Two entries buffered, rst=0 one cycle -> next cycle valid_o=0, count_o=0, drop_o=0, res_o=0x0000.
